// File: rtl/rggen_bus_arbiter_pkg.sv
// Shared types for the register-bus arbiter: response status encoding and width helpers.
package rggen_bus_arbiter_pkg;

  // Same encoding as the rggen_rtl_pkg status enum.
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;

  function automatic int count_width(int max_value);
    return (max_value > 0) ? $clog2(max_value + 1) : 1;
  endfunction

endpackage

// File: rtl/rggen_bus_arbiter_if.sv
// Host-side and downstream signals of the arbiter; slave = arbiter view, master = hosts/bus view.
interface rggen_bus_arbiter_if #(
  parameter int N_HOSTS       = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
);
  import rggen_bus_arbiter_pkg::*;

  logic [N_HOSTS-1:0]                     i_request;
  logic [N_HOSTS-1:0][ADDRESS_WIDTH-1:0]  i_address;
  logic [N_HOSTS-1:0]                     i_write;
  logic [N_HOSTS-1:0][DATA_WIDTH-1:0]     i_write_data;
  logic [N_HOSTS-1:0][DATA_WIDTH/8-1:0]   i_strobe;
  logic [N_HOSTS-1:0]                     o_done;
  logic [DATA_WIDTH-1:0]                  o_read_data;
  rggen_status                            o_status;
  logic                                   o_request;
  logic [ADDRESS_WIDTH-1:0]               o_address;
  logic                                   o_write;
  logic [DATA_WIDTH-1:0]                  o_write_data;
  logic [DATA_WIDTH/8-1:0]                o_strobe;
  logic                                   i_done;
  logic [DATA_WIDTH-1:0]                  i_read_data;
  rggen_status                            i_status;
  logic [N_HOSTS-1:0]                     o_grant;

  modport slave (
    input  i_request, i_address, i_write, i_write_data, i_strobe,
    input  i_done, i_read_data, i_status,
    output o_done, o_read_data, o_status, o_request, o_address,
    output o_write, o_write_data, o_strobe, o_grant
  );

  modport master (
    output i_request, i_address, i_write, i_write_data, i_strobe,
    output i_done, i_read_data, i_status,
    input  o_done, o_read_data, o_status, o_request, o_address,
    input  o_write, o_write_data, o_strobe, o_grant
  );

endinterface

// File: rtl/rggen_round_robin_selector.sv
// Combinational round-robin pick: first set request at or after last_grant+1, wrapping.
module rggen_round_robin_selector #(
  parameter int N_HOSTS = 2
) (
  input  logic [N_HOSTS-1:0]         request,
  input  logic [$clog2(N_HOSTS)-1:0] last_grant,
  output logic [N_HOSTS-1:0]         select,
  output logic [$clog2(N_HOSTS)-1:0] index,
  output logic                       valid
);
  localparam int INDEX_WIDTH = $clog2(N_HOSTS);
  localparam int SUM_WIDTH   = INDEX_WIDTH + 1;

  logic [SUM_WIDTH-1:0]   sum;
  logic [INDEX_WIDTH-1:0] position;

  always_comb begin
    select   = '0;
    index    = '0;
    valid    = 1'b0;
    sum      = '0;
    position = '0;
    // One extra bit on the sum so last_grant+offset cannot overflow before the wrap.
    for (int offset = 1; offset <= N_HOSTS; offset++) begin
      sum = {1'b0, last_grant} + SUM_WIDTH'(offset);
      if (sum >= SUM_WIDTH'(N_HOSTS)) begin
        sum = sum - SUM_WIDTH'(N_HOSTS);
      end
      position = sum[INDEX_WIDTH-1:0];
      if (!valid && request[position]) begin
        valid            = 1'b1;
        select[position] = 1'b1;
        index            = position;
      end
    end
  end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Round-robin arbiter sharing one register bus between N_HOSTS masters, with optional
// timeout that turns a stalled downstream access into a slave-error response.
module rggen_bus_arbiter
  import rggen_bus_arbiter_pkg::*;
#(
  parameter int N_HOSTS        = 2,
  parameter int ADDRESS_WIDTH  = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  rggen_bus_arbiter_if.slave bus
);
  localparam int INDEX_WIDTH = $clog2(N_HOSTS);
  localparam int COUNT_WIDTH = count_width(TIMEOUT_CYCLES);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST =
    (TIMEOUT_CYCLES > 0) ? COUNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [INDEX_WIDTH-1:0]   grant_index;
  logic [INDEX_WIDTH-1:0]   last_grant;
  logic [N_HOSTS-1:0]       grant_onehot;
  logic [N_HOSTS-1:0]       select_onehot;
  logic [INDEX_WIDTH-1:0]   select_index;
  logic                     select_valid;
  logic [COUNT_WIDTH-1:0]   count;
  logic                     timeout;
  logic                     finish;
  logic                     start;

  rggen_round_robin_selector #(
    .N_HOSTS (N_HOSTS)
  ) u_selector (
    .request    (bus.i_request),
    .last_grant (last_grant),
    .select     (select_onehot),
    .index      (select_index),
    .valid      (select_valid)
  );

  // i_done has priority over an expiring timeout in the same cycle.
  assign timeout = (TIMEOUT_CYCLES > 0) && (state == BUSY) && !bus.i_done &&
                   (count == TIMEOUT_LAST);
  assign finish  = (state == BUSY) && (bus.i_done || timeout);
  assign start   = (state == IDLE) && select_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    bus.o_request    = 1'b0;
    bus.o_grant      = '0;
    bus.o_done       = '0;
    bus.o_read_data  = bus.i_read_data;
    bus.o_status     = bus.i_status;
    case (state)
      IDLE: begin
        if (select_valid) begin
          state_next = BUSY;
        end
      end
      BUSY: begin
        bus.o_request = 1'b1;
        bus.o_grant   = grant_onehot;
        if (finish) begin
          bus.o_done = grant_onehot;
          state_next = IDLE;
        end
        if (timeout) begin
          bus.o_read_data = '0;
          bus.o_status    = RGGEN_SLAVE_ERROR;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_index  <= '0;
      grant_onehot <= '0;
      last_grant   <= INDEX_WIDTH'(N_HOSTS - 1);
      count        <= '0;
    end else if (start) begin
      grant_index  <= select_index;
      grant_onehot <= select_onehot;
      count        <= '0;
    end else if (finish) begin
      last_grant   <= grant_index;
    end else if (state == BUSY) begin
      count        <= count + 1'b1;
    end
  end

  // Command is latched at grant so host-side changes mid-access are invisible downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_address    <= '0;
      bus.o_write      <= 1'b0;
      bus.o_write_data <= '0;
      bus.o_strobe     <= '0;
    end else if (start) begin
      bus.o_address    <= bus.i_address[select_index];
      bus.o_write      <= bus.i_write[select_index];
      bus.o_write_data <= bus.i_write_data[select_index];
      bus.o_strobe     <= bus.i_strobe[select_index];
    end
  end

endmodule
